// File: rtl/if_id_stage_reg_pkg.sv
// Shared constants for the IF/ID pipeline register: default widths, the bubble
// encoding and the position of the ARM condition field.
package if_id_stage_reg_pkg;

    localparam int          DEF_WORD_W   = 32;
    localparam int          DEF_CNT_W    = 16;
    localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0000;

    localparam int COND_MSB = 31;
    localparam int COND_LSB = 28;
    localparam int COND_W   = COND_MSB - COND_LSB + 1;

endpackage

// File: rtl/if_id_stage_reg_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: loads PC+4 and instruction, holds on freeze, squashes
// to a bubble on flush, and counts stalled and squashed valid slots.
module if_id_stage_reg
    import if_id_stage_reg_pkg::*;
#(
    parameter int                WORD_W   = DEF_WORD_W,
    parameter int                CNT_W    = DEF_CNT_W,
    parameter logic [WORD_W-1:0] NOP_INSN = DEF_NOP_INSN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              fetch_valid,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] instruction_in,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] instruction_out,
    output logic              valid_out,
    output logic [COND_W-1:0] cond_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [COND_W-1:0] NOP_COND = NOP_INSN[COND_MSB:COND_LSB];

    logic stall_event;
    logic flush_event;

    // Flush wins over freeze, so a simultaneous pair is only ever a flush event.
    assign flush_event = flush && valid_out;
    assign stall_event = !flush && freeze && valid_out;

    // An invalid fetch is stored as the bubble encoding so no stale word leaks to ID.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out          <= '0;
            instruction_out <= NOP_INSN;
            cond_out        <= NOP_COND;
            valid_out       <= 1'b0;
        end else if (flush) begin
            pc_out          <= pc_in;
            instruction_out <= NOP_INSN;
            cond_out        <= NOP_COND;
            valid_out       <= 1'b0;
        end else if (!freeze) begin
            pc_out    <= pc_in;
            valid_out <= fetch_valid;
            if (fetch_valid) begin
                instruction_out <= instruction_in;
                cond_out        <= instruction_in[COND_MSB:COND_LSB];
            end else begin
                instruction_out <= NOP_INSN;
                cond_out        <= NOP_COND;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_event),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_event),
        .count (flush_cnt)
    );

endmodule
